// File: rtl/sorted_loader_pkg.sv
// Shared types and default sizes for the sorted loader fill stage.
package sorted_loader_pkg;

  localparam int unsigned DEF_N    = 32;
  localparam int unsigned DEF_LOGN = 5;
  localparam int unsigned DEF_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CMP  = 2'd2,
    S_INS  = 2'd3
  } state_t;

endpackage : sorted_loader_pkg

// File: rtl/sorted_loader_if.sv
// Input handshake plus external single-port RAM bus for the sorted loader.
interface sorted_loader_if
  import sorted_loader_pkg::*;
#(
  parameter int unsigned LOGN = DEF_LOGN,
  parameter int unsigned W    = DEF_W
) ();

  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            in_ready;
  logic [LOGN-1:0] ram_addr;
  logic [W-1:0]    ram_wdata;
  logic            ram_we;
  logic [W-1:0]    ram_rdata;

  // Producer of values and owner of the RAM
  modport master (
    output in_valid, in_data, ram_rdata,
    input  in_ready, ram_addr, ram_wdata, ram_we
  );

  // The loader itself
  modport slave (
    input  in_valid, in_data, ram_rdata,
    output in_ready, ram_addr, ram_wdata, ram_we
  );

endinterface : sorted_loader_if

// File: rtl/sorted_loader_control.sv
// Insertion FSM: accept, read neighbour, compare/shift, insert.
module sorted_loader_control
  import sorted_loader_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic in_valid,
  input  logic full,
  input  logic cnt_zero,
  input  logic hole_is_one,
  input  logic rd_gt_v,
  output logic in_ready_c,
  output logic accept_c,
  output logic clear_c,
  output logic rd_c,
  output logic shift_c,
  output logic ins_c,
  output logic busy
);

  state_t state_q;
  state_t state_d;

  // State register; busy is registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
    end
  end

  // Next-state and per-state strobes for the datapath
  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    accept_c   = 1'b0;
    clear_c    = 1'b0;
    rd_c       = 1'b0;
    shift_c    = 1'b0;
    ins_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_c = !full && !reset && !clear;
        if (clear) begin
          clear_c = 1'b1;
        end else if (in_valid && in_ready_c) begin
          accept_c = 1'b1;
          state_d  = cnt_zero ? S_INS : S_RD;
        end
      end
      S_RD: begin
        rd_c    = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        if (rd_gt_v) begin
          shift_c = 1'b1;
          state_d = hole_is_one ? S_INS : S_RD;
        end else begin
          state_d = S_INS;
        end
      end
      S_INS: begin
        ins_c   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule : sorted_loader_control

// File: rtl/sorted_loader_datapath.sv
// Value/hole/count registers, neighbour compare and RAM port muxing.
module sorted_loader_datapath
  import sorted_loader_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned LOGN = DEF_LOGN,
  parameter int unsigned W    = DEF_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            accept_c,
  input  logic            clear_c,
  input  logic            rd_c,
  input  logic            shift_c,
  input  logic            ins_c,
  input  logic [W-1:0]    in_data,
  input  logic [W-1:0]    ram_rdata,
  output logic [LOGN-1:0] ram_addr_c,
  output logic [W-1:0]    ram_wdata_c,
  output logic            ram_we_c,
  output logic [LOGN:0]   count,
  output logic            full,
  output logic            cnt_zero,
  output logic            hole_is_one,
  output logic            rd_gt_v
);

  localparam int unsigned CW = LOGN + 1;

  logic [W-1:0]    v_q;
  logic [LOGN-1:0] hole_q;
  logic [CW-1:0]   count_d;

  // Next table size: clear empties, a completed insert adds one
  always_comb begin
    count_d = count;
    if (clear_c) begin
      count_d = '0;
    end else if (ins_c) begin
      count_d = count + CW'(1);
    end
  end

  // Latched value, free slot and table size
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      hole_q <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (accept_c) begin
        v_q    <= in_data;
        hole_q <= count[LOGN-1:0];
      end else if (shift_c) begin
        hole_q <= hole_q - LOGN'(1);
      end
      count <= count_d;
      full  <= (count_d == CW'(N));
    end
  end

  // RAM port: read below the hole, shift into the hole, or drop v into it
  always_comb begin
    ram_addr_c  = '0;
    ram_wdata_c = v_q;
    ram_we_c    = 1'b0;
    if (rd_c) begin
      ram_addr_c = hole_q - LOGN'(1);
    end
    if (shift_c) begin
      ram_addr_c  = hole_q;
      ram_wdata_c = ram_rdata;
      ram_we_c    = !reset;
    end
    if (ins_c) begin
      ram_addr_c  = hole_q;
      ram_wdata_c = v_q;
      ram_we_c    = !reset;
    end
  end

  // Status back to the FSM
  assign cnt_zero    = (count == '0);
  assign hole_is_one = (hole_q == LOGN'(1));
  assign rd_gt_v     = (ram_rdata > v_q);

endmodule : sorted_loader_datapath

// File: rtl/sorted_loader.sv
// Insertion-sort fill stage keeping an external RAM in ascending order.
module sorted_loader
  import sorted_loader_pkg::*;
#(
  parameter int unsigned N    = DEF_N,
  parameter int unsigned LOGN = DEF_LOGN,
  parameter int unsigned W    = DEF_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  sorted_loader_if.slave bus,
  output logic [LOGN:0]  count,
  output logic           full,
  output logic           busy
);

  logic            in_ready_c;
  logic            accept_c;
  logic            clear_c;
  logic            rd_c;
  logic            shift_c;
  logic            ins_c;
  logic            cnt_zero;
  logic            hole_is_one;
  logic            rd_gt_v;
  logic [LOGN-1:0] ram_addr_c;
  logic [W-1:0]    ram_wdata_c;
  logic            ram_we_c;

  sorted_loader_control u_control (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (bus.in_valid),
    .full        (full),
    .cnt_zero    (cnt_zero),
    .hole_is_one (hole_is_one),
    .rd_gt_v     (rd_gt_v),
    .in_ready_c  (in_ready_c),
    .accept_c    (accept_c),
    .clear_c     (clear_c),
    .rd_c        (rd_c),
    .shift_c     (shift_c),
    .ins_c       (ins_c),
    .busy        (busy)
  );

  sorted_loader_datapath #(
    .N    (N),
    .LOGN (LOGN),
    .W    (W)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .accept_c    (accept_c),
    .clear_c     (clear_c),
    .rd_c        (rd_c),
    .shift_c     (shift_c),
    .ins_c       (ins_c),
    .in_data     (bus.in_data),
    .ram_rdata   (bus.ram_rdata),
    .ram_addr_c  (ram_addr_c),
    .ram_wdata_c (ram_wdata_c),
    .ram_we_c    (ram_we_c),
    .count       (count),
    .full        (full),
    .cnt_zero    (cnt_zero),
    .hole_is_one (hole_is_one),
    .rd_gt_v     (rd_gt_v)
  );

  // Drive the interface outputs
  assign bus.in_ready  = in_ready_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;
  assign bus.ram_we    = ram_we_c;

endmodule : sorted_loader

// File: tb/tb_sorted_loader.sv
// Self-checking bench for sorted_loader: vector table, corner sequences, random run.
module tb_sorted_loader;

  localparam int unsigned N    = 32;
  localparam int unsigned LOGN = 5;
  localparam int unsigned W    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [LOGN:0] count;
  logic          full;
  logic          busy;

  sorted_loader_if #(.LOGN(LOGN), .W(W)) bus ();

  sorted_loader #(.N(N), .LOGN(LOGN), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .count (count),
    .full  (full),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // External RAM model with write log
  logic [W-1:0] mem [N];
  int           wr_cnt = 0;
  int           last_wr_addr = -1;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
      wr_cnt            <= wr_cnt + 1;
      last_wr_addr      <= int'(bus.ram_addr);
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Reference: the sorted table as a queue
  logic [W-1:0] model_q [$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_mem(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < model_q.size(); i++)
      if (mem[i] !== model_q[i]) bad++;
    chk(name, bad, 0);
  endtask

  // Stable insert; returns the busy time the timing rules predict
  task automatic model_insert(input logic [W-1:0] v, output int exp_busy);
    int c, idx, k;
    c   = model_q.size();
    idx = c;
    for (int i = 0; i < c; i++) begin
      if (model_q[i] > v) begin
        idx = i;
        break;
      end
    end
    k = c - idx;
    if (c == 0)     exp_busy = 1;
    else if (k < c) exp_busy = 2 * (k + 1) + 1;
    else            exp_busy = 2 * k + 1;
    model_q.insert(idx, v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_q.delete();
  endtask

  // Called at a negedge; returns at the negedge where busy has dropped
  task automatic push(input logic [W-1:0] val, output int bcycles);
    int guard;
    guard = 0;
    #1;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) chk("push_ready_wait", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = val;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bcycles = 0;
    while (busy && bcycles < 200) begin
      bcycles++;
      @(negedge clk);
    end
  endtask

  task automatic push_and_check(input logic [W-1:0] val, input string tag);
    int eb, b;
    model_insert(val, eb);
    push(val, b);
    chk({tag, "_busy"}, b, eb);
    chk({tag, "_count"}, int'(count), model_q.size());
    chk_mem({tag, "_ram"});
  endtask

  typedef struct {
    bit           rst;
    logic [W-1:0] val;
    int           busy;
    int           cnt;
    int           nwr;
    int           ins_addr;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int b, eb, w0, lastb;
    logic [W-1:0] v;

    reset        = 1'b1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ram_we", int'(bus.ram_we), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", int'(bus.in_ready), 1);

    // First insertion, cycle by cycle
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("c1_busy", int'(busy), 1);
    chk("c1_ram_we", int'(bus.ram_we), 1);
    chk("c1_ram_addr", int'(bus.ram_addr), 0);
    chk("c1_ram_wdata", int'(bus.ram_wdata), 5);
    chk("c1_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("c2_count", int'(count), 1);
    chk("c2_busy", int'(busy), 0);
    chk("c2_in_ready", int'(bus.in_ready), 1);
    chk("c2_mem0", int'(mem[0]), 5);

    // Vector table: {reset first, value, busy, count, writes, insert address}
    vecs[0]  = '{1'b1, 8'd5,  1, 1, 1, 0};
    vecs[1]  = '{1'b1, 8'd10, 1, 1, 1, 0};
    vecs[2]  = '{1'b0, 8'd20, 3, 2, 1, 1};
    vecs[3]  = '{1'b0, 8'd30, 3, 3, 1, 2};
    vecs[4]  = '{1'b0, 8'd15, 7, 4, 3, 1};
    vecs[5]  = '{1'b0, 8'd1,  9, 5, 5, 0};
    vecs[6]  = '{1'b1, 8'd10, 1, 1, 1, 0};
    vecs[7]  = '{1'b0, 8'd20, 3, 2, 1, 1};
    vecs[8]  = '{1'b0, 8'd30, 3, 3, 1, 2};
    vecs[9]  = '{1'b0, 8'd15, 7, 4, 3, 1};
    vecs[10] = '{1'b0, 8'd20, 5, 5, 2, 3};
    vecs[11] = '{1'b0, 8'd25, 5, 6, 2, 4};
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst) do_reset();
      w0 = wr_cnt;
      model_insert(vecs[i].val, eb);
      push(vecs[i].val, b);
      chk($sformatf("vec%0d_busy", i), b, vecs[i].busy);
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d_writes", i), wr_cnt - w0, vecs[i].nwr);
      chk($sformatf("vec%0d_ins_addr", i), last_wr_addr, vecs[i].ins_addr);
      chk_mem($sformatf("vec%0d_ram", i));
    end

    // Fill with 31 down to 0: every insertion shifts the whole table
    do_reset();
    lastb = 0;
    for (int i = 31; i >= 0; i--) begin
      v = W'(i);
      model_insert(v, eb);
      push(v, b);
      chk($sformatf("fill%0d_busy", i), b, eb);
      lastb = b;
    end
    chk("fill_worst_busy", lastb, 63);
    chk_mem("fill_ram");
    for (int i = 0; i < 32; i++)
      if (mem[i] !== W'(i)) chk($sformatf("fill_mem%0d", i), int'(mem[i]), i);
    chk("fill_count", int'(count), 32);
    chk("fill_full", int'(full), 1);
    #1;
    chk("fill_in_ready", int'(bus.in_ready), 0);
    w0 = wr_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("full_no_write", wr_cnt - w0, 0);
    chk("full_no_count", int'(count), 32);
    chk("full_not_busy", int'(busy), 0);

    // Reset in the middle of a shifting compare
    do_reset();
    push_and_check(8'd10, "mid_a");
    push_and_check(8'd20, "mid_b");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_cmp_shift_we", int'(bus.ram_we), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_ram_we", int'(bus.ram_we), 0);
    reset = 1'b0;
    model_q.delete();

    // Clear in idle with a value offered the same cycle
    push_and_check(8'd40, "clr_a");
    push_and_check(8'd50, "clr_b");
    push_and_check(8'd60, "clr_c");
    w0 = wr_cnt;
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    #1;
    chk("clear_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clear_count", int'(count), 0);
    chk("clear_no_write", wr_cnt - w0, 0);
    chk("clear_busy", int'(busy), 0);
    model_q.delete();

    // Clear while busy is ignored
    push_and_check(8'd40, "cb_a");
    push_and_check(8'd50, "cb_b");
    push_and_check(8'd60, "cb_c");
    model_insert(8'd200, eb);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd200;
    @(negedge clk);
    bus.in_valid = 1'b0;
    clear        = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    b = 0;
    while (busy && b < 200) begin
      b++;
      @(negedge clk);
    end
    chk("clear_busy_ignored", int'(count), 4);
    chk_mem("clear_busy_ram");

    // Random pushes against the queue model
    do_reset();
    for (int it = 0; it < 150; it++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0 || model_q.size() == N) begin
        if (model_q.size() == N) chk("rnd_full", int'(full), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_q.delete();
        chk("rnd_clear_count", int'(count), 0);
      end else begin
        if (r < 8) v = W'($urandom_range(0, 7));
        else       v = W'($urandom_range(0, 255));
        if (r == 19) repeat (2) @(negedge clk);
        push_and_check(v, $sformatf("rnd%0d", it));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_sorted_loader
